// File: rtl/mdu_controller.sv
// HI/LO multiply/divide sequencer for the E stage: computes results at issue,
// models the fixed unit latency with a countdown and commits to HI/LO at completion.
module mdu_controller #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CW = 4;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   phi_q, phi_d, plo_q, plo_d;
    logic          pwr_q, pwr_d;
    logic          accept;

    logic signed [63:0] smul;
    logic [63:0]        umul;
    logic [31:0]        squo, srem, uquo, urem;

    // Result datapath; the one signed-divide overflow case is pinned explicitly.
    always_comb begin
        smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul = {32'd0, a} * {32'd0, b};
        squo = 32'd0;
        srem = 32'd0;
        uquo = 32'd0;
        urem = 32'd0;
        if (b != 32'd0) begin
            uquo = a / b;
            urem = a % b;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                squo = a;
                srem = 32'd0;
            end else begin
                squo = 32'($signed(a) / $signed(b));
                srem = 32'($signed(a) % $signed(b));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2])          accept = 1'b1;
                    else if (op == 3'd4) hi_d = a;
                    else if (op == 3'd5) lo_d = a;
                end
            end
            RUN: begin
                if (cnt_q == CW'(1)) begin
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                    // Commit edge doubles as an issue slot for the next multi-cycle op.
                    accept  = start && !op[2];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = RUN;
            cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pwr_d   = 1'b1;
            case (op[1:0])
                2'd0: {phi_d, plo_d} = smul;
                2'd1: {phi_d, plo_d} = umul;
                2'd2: begin
                    {phi_d, plo_d} = {srem, squo};
                    pwr_d          = (b != 32'd0);
                end
                default: begin
                    {phi_d, plo_d} = {urem, uquo};
                    pwr_d          = (b != 32'd0);
                end
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = use_d & (busy | (start & ~op[2]));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_controller.sv
// Self-checking bench for mdu_controller: directed vector table, multi-cycle
// corner sequences and random ops checked against an arithmetic reference model.
module tb_mdu_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        use_d;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .use_d(use_d), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result of one issue, from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output int cyc);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        eh = m_hi;
        el = m_lo;
        cyc = 0;
        case (o)
            3'd0: begin sp = sx * sy; eh = sp[63:32]; el = sp[31:0]; cyc = 5; end
            3'd1: begin up = ux * uy; eh = up[63:32]; el = up[31:0]; cyc = 5; end
            3'd2: begin
                cyc = 10;
                if (y != 0) begin sq = sx / sy; sr = sx % sy; eh = sr[31:0]; el = sq[31:0]; end
            end
            3'd3: begin
                cyc = 10;
                if (y != 0) begin eh = x % y; el = x / y; end
            end
            3'd4: eh = x;
            3'd5: el = x;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic ud, input string nm);
        logic [31:0] eh, el;
        int cyc, n;
        model(o, x, y, eh, el, cyc);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; use_d = ud;
        #1 check({nm, " stall_issue"}, 64'(stall), 64'(ud && !o[2]));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            check({nm, " stall_run"}, 64'(stall), 64'(ud));
            check({nm, " hold"}, {hi, lo}, {m_hi, m_lo});
            n++;
            @(negedge clk);
        end
        check({nm, " cycles"}, 64'(n), 64'(cyc));
        check({nm, " hilo"}, {hi, lo}, {eh, el});
        check({nm, " stall_after"}, 64'(stall), 64'd0);
        use_d = 1'b0;
        m_hi = eh;
        m_lo = el;
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] x, y, eh, el;
        logic        ud;
    } vec_t;

    vec_t vt[8];

    initial begin
        int n;
        vt[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        vt[1] = '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vt[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
        vt[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
        vt[4] = '{3'd4, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'h8000_0000, 1'b1};
        vt[5] = '{3'd5, 32'h0000_5678, 32'd0,          32'h0000_1234, 32'h0000_5678, 1'b0};
        vt[6] = '{3'd3, 32'h0000_0063, 32'd0,          32'h0000_1234, 32'h0000_5678, 1'b1};
        vt[7] = '{3'd7, 32'hDEAD_BEEF, 32'd5,          32'h0000_1234, 32'h0000_5678, 1'b1};

        rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; use_d = 1'b0;
        #12 check("reset_state", {31'd0, busy, hi, lo}, 64'd0);
        rst_n = 1'b1;

        // Abort an in-flight MULT with reset; it must never commit.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("reset_abort", {31'd0, busy, hi, lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("reset_no_commit", {31'd0, busy, hi, lo}, 64'd0);

        foreach (vt[i]) begin
            do_op(vt[i].o, vt[i].x, vt[i].y, vt[i].ud, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), {hi, lo}, {vt[i].eh, vt[i].el});
        end

        // MULTU 2x3, MTLO mid-RUN (ignored), DIVU 10/3 issued on the commit edge.
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd2; b = 32'd3;
        @(negedge clk); start = 1'b0;                       // n1
        @(negedge clk); start = 1'b1; op = 3'd5; a = 32'hAAAA_AAAA; // n2
        @(negedge clk); start = 1'b0;                       // n3
        check("b2b mtlo_ignored", {31'd0, busy, lo}, {31'd0, 1'b1, 32'h0000_5678});
        @(negedge clk);                                     // n4
        @(negedge clk);                                     // n5
        start = 1'b1; op = 3'd3; a = 32'd10; b = 32'd3;
        @(negedge clk); start = 1'b0;                       // n6
        check("b2b first", {31'd0, busy, hi, lo}, {31'd0, 1'b1, 32'd0, 32'd6});
        n = 0;
        while (busy && n < 20) begin n++; @(negedge clk); end
        check("b2b div_cycles", 64'(n), 64'd10);
        check("b2b second", {hi, lo}, {32'd1, 32'd3});
        m_hi = 32'd1; m_lo = 32'd3;

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] rx, ry;
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: ry = 32'hFFFF_FFFF;
                2: ry = 32'($urandom_range(1, 9));
                default: ry = $urandom;
            endcase
            do_op(ro, rx, ry, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_controller.md
# mdu_controller

Multiply/divide unit sequencer for the pipelined MIPS core, sitting in the E stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issues, models the fixed multi-cycle latency of the HI/LO unit with a countdown, and commits results to HI/LO at completion. It raises the D-stage stall request while an operation is in flight and a dependent instruction is decoding.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles busy is held for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, cycles busy is held for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is an MDU op this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op
- a  input  32  rs operand
- b  input  32  rt operand
- use_d  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  output  1  multi-cycle op in flight
- stall  output  1  stall request to the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN. Reset (rst_n low, any time, asynchronous): state IDLE, counter 0, busy 0, hi 0, lo 0, pending results 0; any in-flight op is aborted and never commits.
- IDLE, start=1, op 0–3: capture pending {hi,lo} computed from a,b at that edge; load counter with MULT_CYCLES (op 0,1) or DIV_CYCLES (op 2,3); go RUN.
- IDLE, start=1, op 4: hi <= a at that edge; op 5: lo <= a. No RUN entry, busy stays 0.
- IDLE, start=1, op 6–7: no effect.
- RUN: counter decrements each edge; on the edge where counter is 1, hi/lo <= pending values, counter 0, go IDLE.
- start while RUN: ignored entirely (any op, including MTHI/MTLO); the hazard unit guarantees this does not happen in normal flow.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product of a,b; MULTU: unsigned.
  - DIV: lo = quotient truncated toward zero, hi = remainder with sign of dividend; 0x80000000 / 0xFFFFFFFF gives lo 0x80000000, hi 0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (b=0, DIV or DIVU): full DIV_CYCLES latency, hi/lo left unchanged at commit.
- busy = (state == RUN).
- stall = use_d & (busy | (start & op is 0–3)). Combinational.

## Timing
- Start sampled at edge k: busy high from k (after edge) for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES); hi/lo change and busy falls at edge k+N.
- New multi-cycle op accepted at edge k+N itself (commit and new capture in same edge; new op's pending values overwrite after commit).
- MTHI/MTLO: hi/lo visible one edge after start.
- hi/lo hold stable throughout RUN; reads (MFHI/MFLO) during RUN see old values, hence stall.
- stall asserts in the start cycle itself when use_d=1, deasserts in the cycle after the commit edge.

## Test plan
- Reset mid-operation: MULT 3×4 issued, rst_n low at cycle 2 -> busy 0, hi=lo=0 immediately, no later commit.
- MULT a=0xFFFFFFFF, b=2 -> busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU by zero after MTHI 0x1234 / MTLO 0x5678 -> busy 10 cycles, hi=0x1234, lo=0x5678 unchanged.
- Stall: MULT issued with use_d=1 held -> stall high in issue cycle plus 5 busy cycles, low after commit; use_d=0 -> stall never high.
- Back-to-back: MULTU 2×3 then start DIVU 10/3 on the commit edge, plus MTLO issued mid-RUN -> hi:lo = 0:6 after first, then hi=1, lo=3 ten cycles later; MTLO ignored.
